// File: rtl/gray_to_binary_stream.sv
// gray_to_binary_stream
// Decodes a stream of Gray-coded words to binary behind a single-entry
// valid/ready output register. Each accepted word is classified against the
// previously accepted word (up, down, hold, illegal jump, or first after
// reset) and illegal jumps are tallied in a saturating counter.
module gray_to_binary_stream #(
    parameter int WIDTH = 3,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic [WIDTH-1:0] out_gray,
    output logic             out_up,
    output logic             out_down,
    output logic             out_hold,
    output logic             out_err,
    output logic [ERR_W-1:0] err_count,
    output logic             first
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = {WIDTH{1'b0}};
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Output register and reference-word state
    logic             r_out_valid;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_up;
    logic             r_down;
    logic             r_hold;
    logic             r_err;
    logic             r_first;
    logic [ERR_W-1:0] r_err_count;
    logic             r_have_prev;
    logic [WIDTH-1:0] r_prev_bin;

    // Combinational decode and classification of the word on the input
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_prev_inc;
    logic [WIDTH-1:0] w_prev_dec;
    logic             w_accept;
    logic             w_xfer;
    logic             w_in_ready;
    logic             w_up;
    logic             w_down;
    logic             w_hold;
    logic             w_err;
    logic             w_first;

    assign w_bin      = gray2bin(in_gray);
    assign w_prev_inc = r_prev_bin + W_ONE;
    assign w_prev_dec = r_prev_bin - W_ONE;
    // A single output slot: room exists when it is empty or being drained now.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_xfer     = r_out_valid && out_ready;

    // Classify the incoming word against the last accepted binary value
    always_comb begin
        w_up    = 1'b0;
        w_down  = 1'b0;
        w_hold  = 1'b0;
        w_err   = 1'b0;
        w_first = 1'b0;
        if (!r_have_prev) begin
            w_first = 1'b1;
        end else if (w_bin == r_prev_bin) begin
            w_hold = 1'b1;
        end else if (w_bin == w_prev_inc) begin
            w_up = 1'b1;
        end else if (w_bin == w_prev_dec) begin
            w_down = 1'b1;
        end else begin
            w_err = 1'b1;
        end
    end

    // Output slot occupancy: fills on accept, empties on transfer without refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    // Output payload loads only on accept, so it stays stable under back-pressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin   <= {WIDTH{1'b0}};
            r_gray  <= {WIDTH{1'b0}};
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_hold  <= 1'b0;
            r_err   <= 1'b0;
            r_first <= 1'b0;
        end else if (w_accept) begin
            r_bin   <= w_bin;
            r_gray  <= in_gray;
            r_up    <= w_up;
            r_down  <= w_down;
            r_hold  <= w_hold;
            r_err   <= w_err;
            r_first <= w_first;
        end
    end

    // Reference word: only accepted words move the comparison baseline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_have_prev <= 1'b0;
            r_prev_bin  <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_have_prev <= 1'b1;
            r_prev_bin  <= w_bin;
        end
    end

    // Saturating illegal-jump counter, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= {ERR_W{1'b0}};
        end else if (w_accept && w_err && (r_err_count != ERR_MAX)) begin
            r_err_count <= r_err_count + ERR_ONE;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_bin   = r_bin;
    assign out_gray  = r_gray;
    assign out_up    = r_up;
    assign out_down  = r_down;
    assign out_hold  = r_hold;
    assign out_err   = r_err;
    assign err_count = r_err_count;
    assign first     = r_first;

endmodule

// File: tb/tb_gray_to_binary_stream.sv
// Directed testbench for gray_to_binary_stream (WIDTH=3): main instance with
// ERR_W=8, second instance with ERR_W=2 for counter saturation.
module tb_gray_to_binary_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_gray;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_bin;
    logic [2:0] out_gray;
    logic       out_up;
    logic       out_down;
    logic       out_hold;
    logic       out_err;
    logic [7:0] err_count;
    logic       first;

    logic       in_valid2;
    logic       in_ready2;
    logic [2:0] in_gray2;
    logic       out_valid2;
    logic       out_ready2;
    logic [2:0] out_bin2;
    logic [2:0] out_gray2;
    logic       out_up2;
    logic       out_down2;
    logic       out_hold2;
    logic       out_err2;
    logic [1:0] err_count2;
    logic       first2;

    int total;
    int bad;

    // flag vector order: {first, up, down, hold, err}
    localparam logic [4:0] F_FIRST = 5'b10000;
    localparam logic [4:0] F_UP    = 5'b01000;
    localparam logic [4:0] F_DOWN  = 5'b00100;
    localparam logic [4:0] F_HOLD  = 5'b00010;
    localparam logic [4:0] F_ERR   = 5'b00001;

    gray_to_binary_stream #(.WIDTH(3), .ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_gray(out_gray),
        .out_up(out_up), .out_down(out_down), .out_hold(out_hold), .out_err(out_err),
        .err_count(err_count), .first(first)
    );

    gray_to_binary_stream #(.WIDTH(3), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_gray(in_gray2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_bin(out_bin2), .out_gray(out_gray2),
        .out_up(out_up2), .out_down(out_down2), .out_hold(out_hold2), .out_err(out_err2),
        .err_count(err_count2), .first(first2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_gray = 3'b000; out_ready = 1'b1;
        in_valid2 = 1'b0; in_gray2 = 3'b000; out_ready2 = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        total++; if ({first, out_up, out_down, out_hold, out_err, out_bin, out_gray} !== 11'd0) begin
            bad++; $display("FAIL reset_fields got=%b exp=0", {first, out_up, out_down, out_hold, out_err, out_bin, out_gray});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_up_stream();
        logic [2:0] g [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        for (int i = 0; i < 8; i++) begin
            logic [4:0] ef;
            logic [2:0] eb;
            ef = (i == 0) ? F_FIRST : F_UP;
            eb = 3'(i);
            in_valid = 1'b1; in_gray = g[i]; out_ready = 1'b1;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL up_in_ready[%0d] got=%b exp=1", i, in_ready); end
            if (i == 0) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL up_latency got=%b exp=0", out_valid); end
            end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL up_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (out_bin !== eb) begin bad++; $display("FAIL up_bin[%0d] got=%0d exp=%0d", i, out_bin, eb); end
            total++; if (out_gray !== g[i]) begin bad++; $display("FAIL up_gray[%0d] got=%b exp=%b", i, out_gray, g[i]); end
            total++; if ({first, out_up, out_down, out_hold, out_err} !== ef) begin
                bad++; $display("FAIL up_flags[%0d] got=%b exp=%b", i, {first, out_up, out_down, out_hold, out_err}, ef);
            end
            total++; if (err_count !== 8'd0) begin bad++; $display("FAIL up_errcnt[%0d] got=%0d exp=0", i, err_count); end
        end
    endtask

    // prev binary is 7: 7->0 up (wrap), 0->0 hold, 0->7 down (wrap)
    task automatic test_wrap();
        logic [2:0] g  [3] = '{3'b000, 3'b000, 3'b100};
        logic [2:0] eb [3] = '{3'd0, 3'd0, 3'd7};
        logic [4:0] ef [3] = '{F_UP, F_HOLD, F_DOWN};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_gray = g[i]; out_ready = 1'b1;
            @(posedge clk); #1;
            total++; if (out_bin !== eb[i]) begin bad++; $display("FAIL wrap_bin[%0d] got=%0d exp=%0d", i, out_bin, eb[i]); end
            total++; if ({first, out_up, out_down, out_hold, out_err} !== ef[i]) begin
                bad++; $display("FAIL wrap_flags[%0d] got=%b exp=%b", i, {first, out_up, out_down, out_hold, out_err}, ef[i]);
            end
        end
    endtask

    // prev binary is 7: ->0 up, ->3 err (count 1), ->3 hold (count stays 1)
    task automatic test_err();
        logic [2:0] g  [3] = '{3'b000, 3'b010, 3'b010};
        logic [2:0] eb [3] = '{3'd0, 3'd3, 3'd3};
        logic [4:0] ef [3] = '{F_UP, F_ERR, F_HOLD};
        logic [7:0] ec [3] = '{8'd0, 8'd1, 8'd1};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_gray = g[i]; out_ready = 1'b1;
            @(posedge clk); #1;
            total++; if (out_bin !== eb[i]) begin bad++; $display("FAIL err_bin[%0d] got=%0d exp=%0d", i, out_bin, eb[i]); end
            total++; if ({first, out_up, out_down, out_hold, out_err} !== ef[i]) begin
                bad++; $display("FAIL err_flags[%0d] got=%b exp=%b", i, {first, out_up, out_down, out_hold, out_err}, ef[i]);
            end
            total++; if (err_count !== ec[i]) begin bad++; $display("FAIL err_count[%0d] got=%0d exp=%0d", i, err_count, ec[i]); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL err_drain got=%b exp=0", out_valid); end
    endtask

    // prev binary is 3: word A = Gray 110 (4), word B = Gray 111 (5) held behind it
    task automatic test_back_to_back();
        in_valid = 1'b1; in_gray = 3'b110; out_ready = 1'b0;
        @(posedge clk); #1;
        in_gray = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if ({out_bin, out_gray} !== {3'd4, 3'b110}) begin
                bad++; $display("FAIL bp_hold_word[%0d] got=%0d/%b exp=4/110", i, out_bin, out_gray);
            end
            total++; if (out_up !== 1'b1) begin bad++; $display("FAIL bp_up[%0d] got=%b exp=1", i, out_up); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_b_valid got=%b exp=1", out_valid); end
        total++; if ({out_bin, out_gray} !== {3'd5, 3'b111}) begin
            bad++; $display("FAIL bp_b_word got=%0d/%b exp=5/111", out_bin, out_gray);
        end
        total++; if ({first, out_up, out_down, out_hold, out_err} !== F_UP) begin
            bad++; $display("FAIL bp_b_flags got=%b exp=%b", {first, out_up, out_down, out_hold, out_err}, F_UP);
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
    endtask

    // ERR_W=2 instance: 0 then alternate 3/0 (all illegal jumps for WIDTH=3)
    task automatic test_saturate();
        logic [2:0] g  [6] = '{3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010};
        logic [1:0] ec [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 6; i++) begin
            in_valid2 = 1'b1; in_gray2 = g[i]; out_ready2 = 1'b1;
            @(posedge clk); #1;
            total++; if (err_count2 !== ec[i]) begin bad++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, err_count2, ec[i]); end
            total++; if (out_err2 !== (i != 0)) begin bad++; $display("FAIL sat_err[%0d] got=%b exp=%b", i, out_err2, (i != 0)); end
        end
        in_valid2 = 1'b0;
    endtask

    // main instance holds err_count=1 and prev binary 5
    task automatic test_async_reset();
        in_valid = 1'b1; in_gray = 3'b000; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b exp=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL ar_err_count got=%0d exp=0", err_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
        @(negedge clk); rst = 1'b0;
        in_valid = 1'b1; in_gray = 3'b011; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_bin !== 3'd2) begin bad++; $display("FAIL ar_next_bin got=%0d exp=2", out_bin); end
        total++; if ({first, out_up, out_down, out_hold, out_err} !== F_FIRST) begin
            bad++; $display("FAIL ar_next_first got=%b exp=%b", {first, out_up, out_down, out_hold, out_err}, F_FIRST);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_up_stream();
        test_wrap();
        test_err();
        test_back_to_back();
        test_saturate();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
